// File: rtl/datapath_pkg.sv
// ----------------------------------------------------------------------------
// datapath_pkg
// Shared definitions for param_datapath and its register file:
//   - ALU operation codes carried in fs[4:2]
//   - bit positions of the N, Z, C, V flags inside the 4-bit status word
//   - memory-port FSM state encoding
// ----------------------------------------------------------------------------
package datapath_pkg;

    // ALU operation codes (fs[4:2])
    localparam logic [2:0] OP_AND   = 3'b000;
    localparam logic [2:0] OP_OR    = 3'b001;
    localparam logic [2:0] OP_ADD   = 3'b010;
    localparam logic [2:0] OP_XOR   = 3'b011;
    localparam logic [2:0] OP_SHL   = 3'b100;
    localparam logic [2:0] OP_SHR   = 3'b101;
    localparam logic [2:0] OP_PASSB = 3'b110;
    localparam logic [2:0] OP_NOTA  = 3'b111;

    // Positions inside status = {N, Z, C, V}
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Memory-port FSM
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/reg_file.sv
// ----------------------------------------------------------------------------
// reg_file
// NREGS x WIDTH register file, synchronous active-high reset to zero.
// Ports:
//   clk, reset            clock / synchronous reset
//   we, wr_addr, wr_data  single write port, takes effect at the clock edge
//   rd_addr_a/rd_data_a   combinational read port A
//   rd_addr_b/rd_data_b   combinational read port B
//   dbg_addr/dbg_data     combinational debug read port
// Index NREGS-1 is the zero register: it always reads 0 and writes to it are
// dropped. There is no write-to-read bypass; a write shows up the next cycle.
// ----------------------------------------------------------------------------
module reg_file
    import datapath_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int NREGS = 32,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr_a,
    output logic [WIDTH-1:0] rd_data_a,
    input  logic [AW-1:0]    rd_addr_b,
    output logic [WIDTH-1:0] rd_data_b,
    input  logic [AW-1:0]    dbg_addr,
    output logic [WIDTH-1:0] dbg_data
);

    localparam logic [AW-1:0] ZERO_IDX = AW'(NREGS - 1);

    logic [WIDTH-1:0] regs [NREGS];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (wr_addr < ZERO_IDX)) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Addresses at or above the zero register read 0; this also covers
    // unused codes when NREGS is not a power of two.
    assign rd_data_a = (rd_addr_a >= ZERO_IDX) ? '0 : regs[rd_addr_a];
    assign rd_data_b = (rd_addr_b >= ZERO_IDX) ? '0 : regs[rd_addr_b];
    assign dbg_data  = (dbg_addr  >= ZERO_IDX) ? '0 : regs[dbg_addr];

endmodule

// File: rtl/param_datapath.sv
// ----------------------------------------------------------------------------
// param_datapath
// Parametrised processor datapath: register file, function-select ALU,
// K/register B mux, latched NZCV flags and a req/ack data-memory port.
// Ports:
//   clk, reset                       clock / synchronous active-high reset
//   write, rd_addr_a, rd_addr_b,     operation issued by the control unit
//   wr_addr, fs, c_in, k, b_sel,
//   flag_en, mem_en, mem_we
//   ready                            datapath accepts an operation this cycle
//   result                           combinational ALU result
//   status                           latched {N,Z,C,V}
//   mem_req, mem_wr, mem_addr,       memory request and captured command
//   mem_wdata
//   mem_rdata, mem_ack               load data and completion strobe
//   dbg_addr, dbg_data               combinational debug register read
//
// Handshake: an operation is taken on any rising edge where ready is 1; inputs
// presented while ready is 0 are ignored. A memory op raises mem_req on the
// following cycle and holds it, with mem_wr/mem_addr/mem_wdata stable, until
// the edge at which mem_ack is sampled high; ready returns the cycle after.
// ----------------------------------------------------------------------------
module param_datapath
    import datapath_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int NREGS = 32,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             write,
    input  logic [AW-1:0]    rd_addr_a,
    input  logic [AW-1:0]    rd_addr_b,
    input  logic [AW-1:0]    wr_addr,
    input  logic [4:0]       fs,
    input  logic             c_in,
    input  logic [WIDTH-1:0] k,
    input  logic             b_sel,
    input  logic             flag_en,
    input  logic             mem_en,
    input  logic             mem_we,
    output logic             ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       status,
    output logic             mem_req,
    output logic             mem_wr,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata,
    input  logic             mem_ack,
    input  logic [AW-1:0]    dbg_addr,
    output logic [WIDTH-1:0] dbg_data
);

    state_t           state, state_next;
    logic [WIDTH-1:0] a_val, b_val, b_op, sum;
    logic             carry;
    logic             is_add;
    logic [3:0]       flags;
    logic [AW-1:0]    cap_wr_addr;
    logic             cap_write;
    logic             rf_we;
    logic [AW-1:0]    rf_waddr;
    logic [WIDTH-1:0] rf_wdata;
    logic             unused_fs0;

    // fs[0] is reserved and carries no function.
    assign unused_fs0 = fs[0];

    reg_file #(
        .WIDTH (WIDTH),
        .NREGS (NREGS),
        .AW    (AW)
    ) u_reg_file (
        .clk       (clk),
        .reset     (reset),
        .we        (rf_we),
        .wr_addr   (rf_waddr),
        .wr_data   (rf_wdata),
        .rd_addr_a (rd_addr_a),
        .rd_data_a (a_val),
        .rd_addr_b (rd_addr_b),
        .rd_data_b (b_val),
        .dbg_addr  (dbg_addr),
        .dbg_data  (dbg_data)
    );

    // ---------------- ALU ----------------
    assign b_op            = (b_sel ? k : b_val) ^ {WIDTH{fs[1]}};
    assign {carry, sum}    = {1'b0, a_val} + {1'b0, b_op} + {{WIDTH{1'b0}}, c_in};
    assign is_add          = (fs[4:2] == OP_ADD);

    always_comb begin
        result = '0;
        case (fs[4:2])
            OP_AND:   result = a_val & b_op;
            OP_OR:    result = a_val | b_op;
            OP_ADD:   result = sum;
            OP_XOR:   result = a_val ^ b_op;
            // The full B' is the shift amount, so anything >= WIDTH yields 0.
            OP_SHL:   result = a_val << b_op;
            OP_SHR:   result = a_val >> b_op;
            OP_PASSB: result = b_op;
            OP_NOTA:  result = ~a_val;
            default:  result = '0;
        endcase
    end

    always_comb begin
        flags         = '0;
        flags[FLAG_N] = result[WIDTH-1];
        flags[FLAG_Z] = (result == '0);
        flags[FLAG_C] = is_add & carry;
        // Overflow: operands agree in sign but the sum does not.
        flags[FLAG_V] = is_add & (a_val[WIDTH-1] == b_op[WIDTH-1])
                               & (sum[WIDTH-1] != a_val[WIDTH-1]);
    end

    // ---------------- register write port ----------------
    // IDLE: ALU writeback. BUSY: load completion into the captured target.
    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = wr_addr;
        rf_wdata = result;
        if (ready) begin
            rf_we = write && !mem_en;
        end else begin
            rf_we    = mem_ack && !mem_wr && cap_write;
            rf_waddr = cap_wr_addr;
            rf_wdata = mem_rdata;
        end
    end

    // ---------------- status and memory command registers ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            status      <= '0;
            mem_wr      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            cap_wr_addr <= '0;
            cap_write   <= 1'b0;
        end else if (ready) begin
            if (flag_en && !mem_en) begin
                status <= flags;
            end
            if (mem_en) begin
                mem_wr      <= mem_we;
                mem_addr    <= result;
                mem_wdata   <= b_val;
                cap_wr_addr <= wr_addr;
                cap_write   <= write;
            end
        end
    end

    // ---------------- memory-port FSM ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        ready      = 1'b0;
        mem_req    = 1'b0;
        case (state)
            ST_IDLE: begin
                ready = 1'b1;
                if (mem_en) begin
                    state_next = ST_BUSY;
                end
            end
            ST_BUSY: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_param_datapath.sv
// ----------------------------------------------------------------------------
// tb_param_datapath
// Directed bench for param_datapath. Driver tasks push expected observations
// into a queue; a monitor on the falling edge pops and compares them, and a
// second monitor checks every new memory request against an expected queue.
// ----------------------------------------------------------------------------
module tb_param_datapath;

    localparam int W  = 64;
    localparam int NR = 32;
    localparam int AW = 5;

    // observation selectors
    localparam int S_DBG    = 0;
    localparam int S_RESULT = 1;
    localparam int S_STATUS = 2;
    localparam int S_READY  = 3;
    localparam int S_REQ    = 4;
    localparam int S_ADDR   = 5;
    localparam int S_WDATA  = 6;
    localparam int S_WR     = 7;

    logic          clk;
    logic          reset;
    logic          write;
    logic [AW-1:0] rd_addr_a, rd_addr_b, wr_addr, dbg_addr;
    logic [4:0]    fs;
    logic          c_in, b_sel, flag_en, mem_en, mem_we, mem_ack;
    logic [W-1:0]  k, mem_rdata;
    logic          ready, mem_req, mem_wr;
    logic [W-1:0]  result, mem_addr, mem_wdata, dbg_data;
    logic [3:0]    status;

    typedef struct packed {
        logic         wr;
        logic [W-1:0] addr;
        logic [W-1:0] data;
    } mem_t;

    logic [W-1:0] exp_q[$];
    int           sel_q[$];
    mem_t         mem_q[$];
    int           errors = 0;
    int           checks = 0;
    logic         req_d  = 1'b0;

    param_datapath #(.WIDTH(W), .NREGS(NR), .AW(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .write     (write),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .wr_addr   (wr_addr),
        .fs        (fs),
        .c_in      (c_in),
        .k         (k),
        .b_sel     (b_sel),
        .flag_en   (flag_en),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .ready     (ready),
        .result    (result),
        .status    (status),
        .mem_req   (mem_req),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .dbg_addr  (dbg_addr),
        .dbg_data  (dbg_data)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard / monitors ----------------
    function automatic logic [W-1:0] observe(input int sel);
        case (sel)
            S_DBG:    return dbg_data;
            S_RESULT: return result;
            S_STATUS: return W'(status);
            S_READY:  return W'(ready);
            S_REQ:    return W'(mem_req);
            S_ADDR:   return mem_addr;
            S_WDATA:  return mem_wdata;
            default:  return W'(mem_wr);
        endcase
    endfunction

    function automatic string sel_name(input int sel);
        case (sel)
            S_DBG:    return "dbg_data";
            S_RESULT: return "result";
            S_STATUS: return "status";
            S_READY:  return "ready";
            S_REQ:    return "mem_req";
            S_ADDR:   return "mem_addr";
            S_WDATA:  return "mem_wdata";
            default:  return "mem_wr";
        endcase
    endfunction

    always @(negedge clk) begin
        logic [W-1:0] e, act;
        int           s;
        mem_t         m, got;
        while (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            s   = sel_q.pop_front();
            act = observe(s);
            checks++;
            if (act !== e) begin
                errors++;
                $display("FAIL %s (dbg_addr=%0d): got 0x%0h expected 0x%0h",
                         sel_name(s), dbg_addr, act, e);
            end
        end
        if (mem_req && !req_d) begin
            got = '{wr: mem_wr, addr: mem_addr, data: mem_wdata};
            checks++;
            if (mem_q.size() == 0) begin
                errors++;
                $display("FAIL mem_request: unexpected request wr=%0b addr=0x%0h data=0x%0h",
                         got.wr, got.addr, got.data);
            end else begin
                m = mem_q.pop_front();
                if (got !== m) begin
                    errors++;
                    $display("FAIL mem_request: got wr=%0b addr=0x%0h data=0x%0h expected wr=%0b addr=0x%0h data=0x%0h",
                             got.wr, got.addr, got.data, m.wr, m.addr, m.data);
                end
            end
        end
        req_d = mem_req;
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sync();
        @(negedge clk);
        #1;
    endtask

    task automatic exp_val(input int sel, input logic [W-1:0] v);
        sel_q.push_back(sel);
        exp_q.push_back(v);
    endtask

    task automatic idle();
        write     = 1'b0;
        rd_addr_a = '0;
        rd_addr_b = '0;
        wr_addr   = '0;
        fs        = 5'b00000;
        c_in      = 1'b0;
        k         = '0;
        b_sel     = 1'b0;
        flag_en   = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_ack   = 1'b0;
    endtask

    task automatic load_const(input logic [AW-1:0] r, input logic [W-1:0] v);
        idle();
        b_sel   = 1'b1;
        fs      = 5'b11000;
        k       = v;
        wr_addr = r;
        write   = 1'b1;
        tick();
        idle();
    endtask

    task automatic check_reg(input logic [AW-1:0] r, input logic [W-1:0] v);
        dbg_addr = r;
        exp_val(S_DBG, v);
        sync();
    endtask

    task automatic alu(input logic [AW-1:0] a, input logic [AW-1:0] b,
                       input logic bs, input logic [W-1:0] kv,
                       input logic [4:0] f, input logic ci, input logic fe,
                       input logic [W-1:0] res);
        idle();
        rd_addr_a = a;
        rd_addr_b = b;
        b_sel     = bs;
        k         = kv;
        fs        = f;
        c_in      = ci;
        flag_en   = fe;
        exp_val(S_RESULT, res);
        sync();
        tick();
        idle();
    endtask

    task automatic check_status(input logic [W-1:0] v);
        exp_val(S_STATUS, v);
        sync();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset     = 1'b1;
        dbg_addr  = '0;
        mem_rdata = '0;
        idle();
        tick();
        tick();
        reset = 1'b0;

        // reset state
        exp_val(S_READY, 64'd1);
        exp_val(S_REQ, 64'd0);
        exp_val(S_STATUS, 64'd0);
        exp_val(S_ADDR, 64'd0);
        exp_val(S_WDATA, 64'd0);
        exp_val(S_WR, 64'd0);
        check_reg(5'd0, 64'd0);

        // load constants r0..r30 = i+1, then try to write the zero register
        for (int i = 0; i < NR - 1; i++) begin
            load_const(AW'(i), W'(i + 1));
        end
        for (int i = 0; i < NR - 1; i++) begin
            check_reg(AW'(i), W'(i + 1));
        end
        load_const(5'd31, 64'd5);
        check_reg(5'd31, 64'd0);

        // subtract 7 - 7: A + ~B + 1 = 0, carry out set
        load_const(5'd2, 64'd7);
        load_const(5'd3, 64'd7);
        alu(5'd2, 5'd3, 1'b0, 64'd0, 5'b01010, 1'b1, 1'b1, 64'd0);
        check_status(64'h6);

        // signed overflow: max positive + 1
        load_const(5'd2, 64'h7FFF_FFFF_FFFF_FFFF);
        alu(5'd2, 5'd0, 1'b1, 64'd1, 5'b01000, 1'b0, 1'b1, 64'h8000_0000_0000_0000);
        check_status(64'h9);

        // flag_en low: flags hold, result still correct
        alu(5'd2, 5'd3, 1'b0, 64'd0, 5'b00000, 1'b0, 1'b0, 64'd7);
        check_status(64'h9);

        // store: address = r1 & ~r3 = 0x40, data = raw r3 = 0xAB
        load_const(5'd1, 64'h40);
        load_const(5'd3, 64'hAB);
        idle();
        rd_addr_a = 5'd1;
        rd_addr_b = 5'd3;
        fs        = 5'b00010;
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_q.push_back('{wr: 1'b1, addr: 64'h40, data: 64'hAB});
        exp_val(S_RESULT, 64'h40);
        sync();
        tick();
        idle();
        exp_val(S_REQ, 64'd1);
        exp_val(S_READY, 64'd0);
        exp_val(S_ADDR, 64'h40);
        exp_val(S_WDATA, 64'hAB);
        exp_val(S_WR, 64'd1);
        sync();
        tick();
        tick();
        exp_val(S_REQ, 64'd1);
        sync();
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        exp_val(S_READY, 64'd1);
        exp_val(S_REQ, 64'd0);
        sync();

        // load into r5 with a stall; control inputs toggled during BUSY
        idle();
        b_sel   = 1'b1;
        fs      = 5'b11000;
        k       = 64'h100;
        mem_en  = 1'b1;
        mem_we  = 1'b0;
        write   = 1'b1;
        wr_addr = 5'd5;
        mem_q.push_back('{wr: 1'b0, addr: 64'h100, data: 64'd1});
        tick();
        idle();
        write   = 1'b1;
        wr_addr = 5'd7;
        b_sel   = 1'b1;
        fs      = 5'b11000;
        k       = 64'hDEAD;
        flag_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
        end
        check_reg(5'd7, 64'd8);
        mem_rdata = 64'h1234;
        mem_ack   = 1'b1;
        tick();
        idle();
        check_reg(5'd5, 64'h1234);
        check_reg(5'd7, 64'd8);
        check_reg(5'd6, 64'd7);
        check_status(64'h9);

        // mem_ack while idle is ignored
        mem_rdata = 64'h5555;
        mem_ack   = 1'b1;
        wr_addr   = 5'd5;
        tick();
        idle();
        exp_val(S_REQ, 64'd0);
        check_reg(5'd5, 64'h1234);

        // reset in the middle of a load, with a coincident ack
        idle();
        b_sel   = 1'b1;
        fs      = 5'b11000;
        k       = 64'h200;
        mem_en  = 1'b1;
        write   = 1'b1;
        wr_addr = 5'd5;
        mem_q.push_back('{wr: 1'b0, addr: 64'h200, data: 64'd1});
        tick();
        idle();
        tick();
        reset     = 1'b1;
        mem_ack   = 1'b1;
        mem_rdata = 64'hFFFF;
        tick();
        reset = 1'b0;
        idle();
        exp_val(S_REQ, 64'd0);
        exp_val(S_READY, 64'd1);
        exp_val(S_STATUS, 64'd0);
        exp_val(S_ADDR, 64'd0);
        check_reg(5'd5, 64'd0);

        // shift boundaries and remaining ops
        load_const(5'd1, 64'd1);
        load_const(5'd2, 64'h8000_0000_0000_0000);
        alu(5'd1, 5'd0, 1'b1, 64'd63, 5'b10000, 1'b0, 1'b0, 64'h8000_0000_0000_0000);
        alu(5'd1, 5'd0, 1'b1, 64'd64, 5'b10000, 1'b0, 1'b0, 64'd0);
        alu(5'd2, 5'd0, 1'b1, 64'd63, 5'b10100, 1'b0, 1'b0, 64'd1);
        alu(5'd2, 5'd0, 1'b1, 64'd64, 5'b10100, 1'b0, 1'b0, 64'd0);
        alu(5'd1, 5'd0, 1'b1, 64'hF0, 5'b01100, 1'b0, 1'b0, 64'hF1);
        alu(5'd1, 5'd0, 1'b1, 64'd6, 5'b00100, 1'b0, 1'b0, 64'd7);
        alu(5'd1, 5'd0, 1'b0, 64'd0, 5'b11100, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE);
        check_status(64'h8);

        // every expected memory request must have been seen
        sync();
        checks++;
        if (mem_q.size() != 0) begin
            errors++;
            $display("FAIL mem_queue_drain: got %0d pending requests expected 0", mem_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
